// File: rtl/phy_pkg.sv
// Shared PHY definitions: width codes, COM symbol and aligner states,
// common to the RX 8-to-32 and TX 32-to-8 converters.
package phy_pkg;

  typedef enum logic [1:0] {
    Pclk32   = 2'b00,
    Pclk16   = 2'b01,
    Pclk8    = 2'b10,
    PclkRsvd = 2'b11
  } pclk_e;

  localparam logic [7:0] ComByte = 8'hBC;

  typedef enum logic {
    StUnaligned = 1'b0,
    StAligned   = 1'b1
  } align_state_e;

  // Bytes per word for a width code; reserved never reaches a byte accept.
  function automatic logic [2:0] word_len(input pclk_e pclk);
    unique case (pclk)
      Pclk32:  word_len = 3'd4;
      Pclk16:  word_len = 3'd2;
      Pclk8:   word_len = 3'd1;
      default: word_len = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/conv_8_32.sv
// RX byte-to-word converter: aligns on COM (K28.5) and packs 1/2/4 bytes per
// word, first byte in the most significant used lane.
module conv_8_32
  import phy_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET_CONV,
  input  logic        ENB,
  input  logic [1:0]  PCLK,
  input  logic [7:0]  in,
  input  logic        valid_in,
  input  logic        K_in,
  output logic [31:0] out,
  output logic [3:0]  K_out,
  output logic        valid_out,
  output logic        aligned,
  output logic        align_err
);

  align_state_e state_q;
  pclk_e        pclk_q;
  logic [1:0]   cnt_q;
  logic [23:0]  buf_q;
  logic [2:0]   kbuf_q;
  logic [31:0]  out_q;
  logic [3:0]   kout_q;
  logic         valid_q;
  logic         err_q;

  pclk_e        pclk;
  logic         upd;
  logic         accept;
  logic         is_com;
  logic [1:0]   eff_cnt;
  logic         pos0;
  logic [31:0]  new_buf;
  logic [3:0]   new_k;
  logic [2:0]   cnt_next;
  logic         word_done;

  always_comb begin
    pclk      = pclk_e'(PCLK);
    upd       = ENB && (pclk != PclkRsvd);
    accept    = upd && valid_in;
    is_com    = accept && K_in && (in == ComByte);
    // A width change abandons any partial word; the byte in hand starts fresh.
    eff_cnt   = (upd && (pclk != pclk_q)) ? 2'd0 : cnt_q;
    pos0      = (state_q == StUnaligned) || is_com || (eff_cnt == 2'd0);
    new_buf   = pos0 ? {24'd0, in} : {buf_q, in};
    new_k     = pos0 ? {3'd0, K_in} : {kbuf_q, K_in};
    cnt_next  = pos0 ? 3'd1 : ({1'b0, eff_cnt} + 3'd1);
    word_done = (cnt_next == word_len(pclk));
  end

  always_ff @(posedge CLK or negedge RESET_CONV) begin
    if (!RESET_CONV) begin
      state_q <= StUnaligned;
      pclk_q  <= Pclk32;
      cnt_q   <= 2'd0;
      buf_q   <= 24'd0;
      kbuf_q  <= 3'd0;
      out_q   <= 32'd0;
      kout_q  <= 4'd0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (upd) begin
        pclk_q <= pclk;
        cnt_q  <= eff_cnt;
      end
      if (accept && ((state_q == StAligned) || is_com)) begin
        state_q <= StAligned;
        if (state_q == StAligned && is_com && eff_cnt != 2'd0) begin
          err_q <= 1'b1;
        end
        if (word_done) begin
          out_q   <= new_buf;
          kout_q  <= new_k;
          valid_q <= 1'b1;
          cnt_q   <= 2'd0;
        end else begin
          buf_q  <= new_buf[23:0];
          kbuf_q <= new_k[2:0];
          cnt_q  <= cnt_next[1:0];
        end
      end
    end
  end

  assign out       = out_q;
  assign K_out     = kout_q;
  assign valid_out = valid_q;
  assign aligned   = (state_q == StAligned);
  assign align_err = err_q;

endmodule
